// File: rtl/icache_axi_rd_bridge.sv
// I-cache refill responder: turns one held refill request into a single-beat
// AXI4 read and hands the returned word back with a one-cycle ok pulse.
module icache_axi_rd_bridge #(
    parameter int unsigned        ADDR_W = 64,
    parameter int unsigned        DATA_W = 64,
    parameter int unsigned        ID_W   = 4,
    parameter logic [ID_W-1:0]    AXI_ID = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    // cache side
    input  logic                  cache_read_ena,
    input  logic [ADDR_W-1:0]     cache_addr,
    output logic [DATA_W-1:0]     cache_or_data,
    output logic                  cache_in_ok,
    output logic                  axi_working_ti,
    output logic                  rd_err,
    // AXI read address channel
    output logic                  axi_ar_valid,
    input  logic                  axi_ar_ready,
    output logic [ADDR_W-1:0]     axi_ar_addr,
    output logic [ID_W-1:0]       axi_ar_id,
    output logic [7:0]            axi_ar_len,
    output logic [2:0]            axi_ar_size,
    output logic [1:0]            axi_ar_burst,
    // AXI read data channel
    input  logic                  axi_r_valid,
    output logic                  axi_r_ready,
    input  logic [DATA_W-1:0]     axi_r_data,
    input  logic [1:0]            axi_r_resp,
    input  logic                  axi_r_last,
    input  logic [ID_W-1:0]       axi_r_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_RD,
        S_DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic                beat_err_c;

    // Beat is flagged bad on a non-OKAY response, foreign ID or missing RLAST
    assign beat_err_c = (axi_r_resp != 2'b00) | (axi_r_id != AXI_ID) | ~axi_r_last;

    // AR payload: latched aligned address; fixed attributes shown only while AR is valid
    assign axi_ar_addr  = addr_q;
    assign axi_ar_len   = 8'h00;
    assign axi_ar_id    = axi_ar_valid ? AXI_ID : ID_W'(0);
    assign axi_ar_size  = axi_ar_valid ? 3'b011 : 3'b000;
    assign axi_ar_burst = axi_ar_valid ? 2'b01  : 2'b00;

    // Request sequencer with all handshake and cache outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            addr_q         <= '0;
            cache_or_data  <= '0;
            cache_in_ok    <= 1'b0;
            axi_working_ti <= 1'b0;
            rd_err         <= 1'b0;
            axi_ar_valid   <= 1'b0;
            axi_r_ready    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cache_read_ena) begin
                        addr_q         <= cache_addr & ~ADDR_W'(7);
                        axi_ar_valid   <= 1'b1;
                        axi_working_ti <= 1'b1;
                        state          <= S_AR;
                    end
                end
                S_AR: begin
                    if (axi_ar_ready) begin
                        axi_ar_valid <= 1'b0;
                        axi_r_ready  <= 1'b1;
                        state        <= S_RD;
                    end
                end
                S_RD: begin
                    if (axi_r_valid) begin
                        axi_r_ready   <= 1'b0;
                        cache_or_data <= axi_r_data;
                        cache_in_ok   <= 1'b1;
                        rd_err        <= beat_err_c;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    cache_in_ok    <= 1'b0;
                    rd_err         <= 1'b0;
                    axi_working_ti <= 1'b0;
                    state          <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Scoreboard bench for icache_axi_rd_bridge: a driver acts as both the cache and
// the AXI slave, pushing the expected refill result; a monitor checks every ok pulse.
module tb_icache_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cache_read_ena;
    logic [63:0] cache_addr;
    logic [63:0] cache_or_data;
    logic        cache_in_ok;
    logic        axi_working_ti;
    logic        rd_err;
    logic        axi_ar_valid;
    logic        axi_ar_ready;
    logic [63:0] axi_ar_addr;
    logic [3:0]  axi_ar_id;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size;
    logic [1:0]  axi_ar_burst;
    logic        axi_r_valid;
    logic        axi_r_ready;
    logic [63:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic        axi_r_last;
    logic [3:0]  axi_r_id;

    icache_axi_rd_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .cache_read_ena (cache_read_ena),
        .cache_addr     (cache_addr),
        .cache_or_data  (cache_or_data),
        .cache_in_ok    (cache_in_ok),
        .axi_working_ti (axi_working_ti),
        .rd_err         (rd_err),
        .axi_ar_valid   (axi_ar_valid),
        .axi_ar_ready   (axi_ar_ready),
        .axi_ar_addr    (axi_ar_addr),
        .axi_ar_id      (axi_ar_id),
        .axi_ar_len     (axi_ar_len),
        .axi_ar_size    (axi_ar_size),
        .axi_ar_burst   (axi_ar_burst),
        .axi_r_valid    (axi_r_valid),
        .axi_r_ready    (axi_r_ready),
        .axi_r_data     (axi_r_data),
        .axi_r_resp     (axi_r_resp),
        .axi_r_last     (axi_r_last),
        .axi_r_id       (axi_r_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] last_data = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          ok_seen = 0;
    int          ok_expected = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every ok pulse consumes one expectation; between pulses data holds and rd_err stays low
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (cache_in_ok) begin
                ok_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ok: got ok=1 expected no pending request at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("ok_data", cache_or_data, e.data);
                    chk("ok_rd_err", 64'(rd_err), 64'(e.err));
                    last_data = e.data;
                end
            end else begin
                chk("hold_data", cache_or_data, last_data);
                chk("err_without_ok", 64'(rd_err), 64'd0);
            end
        end
    end

    // One refill: cache request plus AXI slave behaviour with the given stalls and R beat.
    // cont: request already held high from the previous hold transaction (we are in the idle cycle).
    task automatic txn(input logic [63:0] addr, input int ar_stall, input int r_stall,
                       input logic [63:0] data, input logic [1:0] resp, input logic [3:0] id,
                       input logic last, input bit cont, input bit hold, input bit toggle);
        exp_t        e;
        logic [63:0] al;
        al     = {addr[63:3], 3'b000};
        e.data = data;
        e.err  = (resp != 2'b00) || (id != 4'h0) || !last;
        if (!cont) begin
            @(posedge clk);
            #1;
        end
        cache_read_ena = 1'b1;
        cache_addr     = addr;
        exp_q.push_back(e);
        ok_expected++;
        @(posedge clk);
        #1;
        if (toggle) cache_addr = 64'h0000_0000_DEAD_0000;
        for (int i = 0; i < ar_stall; i++) begin
            @(negedge clk);
            chk("ar_valid_stall", 64'(axi_ar_valid), 64'd1);
            chk("ar_addr_stall", axi_ar_addr, al);
            chk("working_ar", 64'(axi_working_ti), 64'd1);
            @(posedge clk);
            #1;
        end
        axi_ar_ready = 1'b1;
        @(negedge clk);
        chk("ar_valid", 64'(axi_ar_valid), 64'd1);
        chk("ar_addr", axi_ar_addr, al);
        chk("ar_len", 64'(axi_ar_len), 64'd0);
        chk("ar_size", 64'(axi_ar_size), 64'd3);
        chk("ar_burst", 64'(axi_ar_burst), 64'd1);
        chk("ar_id", 64'(axi_ar_id), 64'd0);
        chk("r_ready_in_ar", 64'(axi_r_ready), 64'd0);
        @(posedge clk);
        #1;
        axi_ar_ready = 1'b0;
        for (int i = 0; i < r_stall; i++) begin
            @(negedge clk);
            chk("ar_valid_dropped", 64'(axi_ar_valid), 64'd0);
            chk("r_ready_wait", 64'(axi_r_ready), 64'd1);
            chk("working_rd", 64'(axi_working_ti), 64'd1);
            chk("no_early_ok", 64'(cache_in_ok), 64'd0);
            @(posedge clk);
            #1;
        end
        axi_r_valid = 1'b1;
        axi_r_data  = data;
        axi_r_resp  = resp;
        axi_r_id    = id;
        axi_r_last  = last;
        @(negedge clk);
        chk("r_ready", 64'(axi_r_ready), 64'd1);
        @(posedge clk);
        #1;
        axi_r_valid = 1'b0;
        axi_r_data  = {$urandom, $urandom};
        axi_r_resp  = 2'($urandom);
        axi_r_last  = 1'b0;
        @(negedge clk);
        chk("ok_latency", 64'(cache_in_ok), 64'd1);
        chk("working_at_ok", 64'(axi_working_ti), 64'd1);
        chk("r_ready_done", 64'(axi_r_ready), 64'd0);
        if (hold) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("idle_gap_ar", 64'(axi_ar_valid), 64'd0);
            chk("idle_gap_working", 64'(axi_working_ti), 64'd0);
            chk("idle_gap_ok", 64'(cache_in_ok), 64'd0);
        end else begin
            @(posedge clk);
            #1;
            cache_read_ena = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ar_valid"}, 64'(axi_ar_valid), 64'd0);
        chk({tag, "_r_ready"}, 64'(axi_r_ready), 64'd0);
        chk({tag, "_ok"}, 64'(cache_in_ok), 64'd0);
        chk({tag, "_err"}, 64'(rd_err), 64'd0);
        chk({tag, "_working"}, 64'(axi_working_ti), 64'd0);
        chk({tag, "_data"}, cache_or_data, 64'd0);
        chk({tag, "_ar_addr"}, axi_ar_addr, 64'd0);
    endtask

    initial begin
        bit          prev_hold;
        bit          hold;
        logic [1:0]  resp;
        logic [3:0]  id;
        cache_read_ena = 1'b0;
        cache_addr     = '0;
        axi_ar_ready   = 1'b0;
        axi_r_valid    = 1'b0;
        axi_r_data     = '0;
        axi_r_resp     = '0;
        axi_r_last     = 1'b0;
        axi_r_id       = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // basic refill, no stalls
        txn(64'h0000_0000_8000_0104, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 4'h0, 1'b1, 0, 0, 0);
        // long AR and R stalls
        txn(64'h0000_0000_8000_0A08, 5, 7, 64'hCAFE_F00D_0BAD_BEEF, 2'b00, 4'h0, 1'b1, 0, 0, 0);
        // SLVERR passed through with error flag
        txn(64'h0000_0000_8000_0010, 1, 2, 64'h0123_4567_89AB_CDEF, 2'b10, 4'h0, 1'b1, 0, 0, 0);
        // request held across DONE: second request follows after one idle cycle
        txn(64'h0000_0000_8000_0020, 0, 1, 64'hAAAA_5555_AAAA_5555, 2'b00, 4'h0, 1'b1, 0, 1, 0);
        txn(64'h0000_0000_8000_0028, 2, 0, 64'h5555_AAAA_5555_AAAA, 2'b00, 4'h0, 1'b1, 1, 0, 0);
        // address changes after acceptance are ignored
        txn(64'h0000_0000_8000_0337, 3, 1, 64'hFEDC_BA98_7654_3210, 2'b00, 4'h0, 1'b1, 0, 0, 1);
        // RID mismatch and missing RLAST both flag an error
        txn(64'h0000_0000_8000_0040, 0, 0, 64'h1111_2222_3333_4444, 2'b00, 4'h3, 1'b1, 0, 0, 0);
        txn(64'h0000_0000_8000_0048, 0, 0, 64'h5555_6666_7777_8888, 2'b00, 4'h0, 1'b0, 0, 0, 0);

        // reset while waiting for the R beat
        @(posedge clk);
        #1;
        cache_read_ena = 1'b1;
        cache_addr     = 64'h0000_0000_8000_0300;
        @(posedge clk);
        #1;
        axi_ar_ready = 1'b1;
        @(posedge clk);
        #1;
        axi_ar_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_r_ready", 64'(axi_r_ready), 64'd1);
        #1;
        rst = 1'b0;
        cache_read_ena = 1'b0;
        last_data = '0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        axi_r_valid = 1'b1;
        axi_r_data  = 64'h9999_9999_9999_9999;
        axi_r_resp  = 2'b00;
        axi_r_id    = 4'h0;
        axi_r_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_r_ready", 64'(axi_r_ready), 64'd0);
            chk("stale_r_ok", 64'(cache_in_ok), 64'd0);
        end
        axi_r_valid = 1'b0;
        txn(64'h0000_0000_8000_0200, 0, 0, 64'h0F0E_0D0C_0B0A_0908, 2'b00, 4'h0, 1'b1, 0, 0, 0);

        // randomized refills against the response rules
        prev_hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            hold = (i < 19) && ($urandom_range(0, 3) == 0);
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            id   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            txn({$urandom, $urandom}, $urandom_range(0, 6), $urandom_range(0, 6),
                {$urandom, $urandom}, resp, id, ($urandom_range(0, 7) != 0),
                prev_hold, hold, ($urandom_range(0, 1) == 1));
            prev_hold = hold;
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("ok_pulse_count", 64'(ok_seen), 64'(ok_expected));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
